wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO. It runs in the write clock domain and produces the write address and `o_wfull` consumed by the `fifomem` storage array. It exports a Gray-coded write pointer for the read domain and synchronizes the read domain's Gray pointer back into `wclk`. It also provides almost-full, occupancy and a sticky overflow error.

---
 rtl/wptr_full.sv | 78 +++++++
 tb/tb_wptr_full.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - async FIFO write-side pointer, full/almost-full flags, occupancy and sticky overflow
module wptr_full #(
    parameter int ASIZE        = 4,
    parameter int AFULL_THRESH = 2**ASIZE - 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             wr_en,
    input  logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE-1:0] wr_addr,
    output logic [ASIZE:0]   wptr,
    output logic             o_wfull,
    output logic             o_walmost_full,
    output logic [ASIZE:0]   wr_count,
    output logic             wr_overflow
);

    localparam logic [ASIZE:0] AFULL_LVL = (ASIZE+1)'(AFULL_THRESH);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] wq1_rptr;
    logic [ASIZE:0] wq2_rptr;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] count_next;
    logic           push;
    logic           full_next;
    logic           afull_next;

    always_comb begin
        push       = wr_en && !o_wfull;
        wbin_next  = wbin + {{ASIZE{1'b0}}, push};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Each binary bit of the synchronized read pointer is the XOR of its Gray bits from that position up.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Full when the write pointer has lapped the (stale) read pointer by exactly one depth.
    always_comb begin
        count_next = wbin_next - rbin;
        full_next  = (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
        afull_next = (count_next >= AFULL_LVL);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin           <= '0;
            wptr           <= '0;
            wq1_rptr       <= '0;
            wq2_rptr       <= '0;
            o_wfull        <= 1'b0;
            o_walmost_full <= 1'b0;
            wr_count       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wptr           <= wgray_next;
            wq1_rptr       <= rptr_gray;
            wq2_rptr       <= wq1_rptr;
            o_wfull        <= full_next;
            o_walmost_full <= afull_next;
            wr_count       <= count_next;
            if (wr_en && o_wfull) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    assign wr_addr = wbin[ASIZE-1:0];

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - scoreboard bench for wptr_full
module tb_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] rptr_gray = '0;
    logic [3:0] wr_addr;
    logic [4:0] wptr;
    logic       o_wfull;
    logic       o_walmost_full;
    logic [4:0] wr_count;
    logic       wr_overflow;

    wptr_full #(.ASIZE(4), .AFULL_THRESH(14)) dut (
        .wclk           (wclk),
        .wrst           (wrst),
        .wr_en          (wr_en),
        .rptr_gray      (rptr_gray),
        .wr_addr        (wr_addr),
        .wptr           (wptr),
        .o_wfull        (o_wfull),
        .o_walmost_full (o_walmost_full),
        .wr_count       (wr_count),
        .wr_overflow    (wr_overflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       full;
        logic       af;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    // Reference model: binary pointers, read pointer seen two edges late.
    logic [4:0] m_wbin = '0;
    logic [4:0] m_q1 = '0;
    logic [4:0] m_q2 = '0;
    logic       m_full = 1'b0;
    logic       m_ovf = 1'b0;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic cycle(input logic rst_i, input logic en_i, input logic [4:0] rd_i);
        exp_t x;
        logic [4:0] cnt;
        @(negedge wclk);
        wrst = rst_i;
        wr_en = en_i;
        rptr_gray = gray(rd_i);
        if (rst_i) begin
            m_wbin = '0; m_q1 = '0; m_q2 = '0; m_full = 1'b0; m_ovf = 1'b0; cnt = '0;
        end else begin
            if (en_i && m_full) m_ovf = 1'b1;
            if (en_i && !m_full) m_wbin = m_wbin + 5'd1;
            cnt = m_wbin - m_q2;
            m_q2 = m_q1;
            m_q1 = rd_i;
            m_full = (cnt == 5'd16);
        end
        x.addr = m_wbin[3:0];
        x.ptr  = gray(m_wbin);
        x.full = m_full;
        x.af   = (cnt >= 5'd14);
        x.cnt  = cnt;
        x.ovf  = m_ovf;
        sb.push_back(x);
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(k < 2, 1'b1 && (k < 2), 5'd0);
            e = sb.pop_front();
            checks++;
            if ({wr_addr, wptr, o_wfull, o_walmost_full, wr_count, wr_overflow} !== 17'd0 ||
                e.cnt !== 5'd0) begin
                failures++;
                $display("FAIL reset[%0d] got addr=%0d ptr=%b full=%b af=%b cnt=%0d ovf=%b required all zero",
                         k, wr_addr, wptr, o_wfull, o_walmost_full, wr_count, wr_overflow);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (wr_addr !== 4'(i)) begin
                failures++;
                $display("FAIL fill_addr_before[%0d] got %0d required %0d", i, wr_addr, i);
            end
            cycle(1'b0, 1'b1, 5'd0);
            e = sb.pop_front();
            checks++;
            if (wr_addr !== e.addr || wptr !== e.ptr || wr_count !== e.cnt ||
                o_wfull !== e.full || o_walmost_full !== e.af) begin
                failures++;
                $display("FAIL fill[%0d] got addr=%0d ptr=%b cnt=%0d full=%b af=%b required addr=%0d ptr=%b cnt=%0d full=%b af=%b",
                         i, wr_addr, wptr, wr_count, o_wfull, o_walmost_full,
                         e.addr, e.ptr, e.cnt, e.full, e.af);
            end
            if (i == 12 || i == 13) begin
                checks++;
                if (o_walmost_full !== (i == 13)) begin
                    failures++;
                    $display("FAIL fill_afull_edge[%0d] got %b required %b", i, o_walmost_full, i == 13);
                end
            end
        end
        checks++;
        if (wptr !== 5'b11000 || wr_count !== 5'd16 || o_wfull !== 1'b1) begin
            failures++;
            $display("FAIL fill_last got ptr=%b cnt=%0d full=%b required ptr=11000 cnt=16 full=1",
                     wptr, wr_count, o_wfull);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] a;
        logic [4:0] p;
        logic [4:0] c;
        a = wr_addr; p = wptr; c = wr_count;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, k < 3, 5'd0);
            e = sb.pop_front();
            checks++;
            if (wr_overflow !== 1'b1 || wr_overflow !== e.ovf || wr_addr !== a || wptr !== p ||
                wr_count !== c || o_wfull !== e.full) begin
                failures++;
                $display("FAIL overflow[%0d] got ovf=%b addr=%0d ptr=%b cnt=%0d full=%b required ovf=1 addr=%0d ptr=%b cnt=%0d full=%b",
                         k, wr_overflow, wr_addr, wptr, wr_count, o_wfull, a, p, c, e.full);
            end
        end
    endtask

    task automatic test_drain_release();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 5'd1);
            e = sb.pop_front();
            checks++;
            if (o_wfull !== e.full || wr_count !== e.cnt || o_walmost_full !== e.af) begin
                failures++;
                $display("FAIL drain[%0d] got full=%b cnt=%0d af=%b required full=%b cnt=%0d af=%b",
                         k, o_wfull, wr_count, o_walmost_full, e.full, e.cnt, e.af);
            end
        end
        checks++;
        if (o_wfull !== 1'b0 || wr_count !== 5'd15 || o_walmost_full !== 1'b1) begin
            failures++;
            $display("FAIL drain_n2 got full=%b cnt=%0d af=%b required full=0 cnt=15 af=1",
                     o_wfull, wr_count, o_walmost_full);
        end
        cycle(1'b0, 1'b1, 5'd1);
        e = sb.pop_front();
        checks++;
        if (o_wfull !== 1'b1 || wr_count !== 5'd16 || wptr !== e.ptr || wr_overflow !== e.ovf) begin
            failures++;
            $display("FAIL drain_refill got full=%b cnt=%0d ptr=%b ovf=%b required full=1 cnt=16 ptr=%b ovf=%b",
                     o_wfull, wr_count, wptr, wr_overflow, e.ptr, e.ovf);
        end
    endtask

    task automatic test_wrap_around();
        int t;
        logic [4:0] rd;
        cycle(1'b1, 1'b0, 5'd0);
        e = sb.pop_front();
        checks++;
        if (wr_overflow !== 1'b0 || wptr !== 5'd0 || wr_count !== 5'd0) begin
            failures++;
            $display("FAIL wrap_reset got ovf=%b ptr=%b cnt=%0d required 0 0 0", wr_overflow, wptr, wr_count);
        end
        t = 0;
        for (int k = 0; k < 40; k++) begin
            rd = (t >= 7) ? 5'(t - 7) : 5'd0;
            cycle(1'b0, 1'b1, rd);
            t++;
            e = sb.pop_front();
            checks++;
            if (wptr !== e.ptr || wr_count !== e.cnt || o_wfull !== 1'b0 || wr_count > 5'd10 ||
                o_walmost_full !== e.af) begin
                failures++;
                $display("FAIL wrap[%0d] got ptr=%b cnt=%0d full=%b af=%b required ptr=%b cnt=%0d full=0 af=%b",
                         k, wptr, wr_count, o_wfull, o_walmost_full, e.ptr, e.cnt, e.af);
            end
            if (t == 32) begin
                checks++;
                if (wptr !== 5'd0 || wr_addr !== 4'd0) begin
                    failures++;
                    $display("FAIL wrap_to_zero got ptr=%b addr=%0d required 0 0", wptr, wr_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        cycle(1'b1, 1'b0, 5'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 5'd0);
            e = sb.pop_front();
            checks++;
            if (wr_addr !== e.addr || wptr !== e.ptr || wr_count !== e.cnt) begin
                failures++;
                $display("FAIL midfill_push[%0d] got addr=%0d ptr=%b cnt=%0d required addr=%0d ptr=%b cnt=%0d",
                         i, wr_addr, wptr, wr_count, e.addr, e.ptr, e.cnt);
            end
        end
        cycle(1'b1, 1'b1, 5'd0);
        e = sb.pop_front();
        checks++;
        if ({wr_addr, wptr, o_wfull, o_walmost_full, wr_count, wr_overflow} !== 17'd0) begin
            failures++;
            $display("FAIL midfill_reset got addr=%0d ptr=%b full=%b af=%b cnt=%0d ovf=%b required all zero",
                     wr_addr, wptr, o_wfull, o_walmost_full, wr_count, wr_overflow);
        end
        cycle(1'b0, 1'b1, 5'd0);
        e = sb.pop_front();
        checks++;
        if (wr_addr !== 4'd1 || wptr !== 5'd1 || wr_count !== e.cnt) begin
            failures++;
            $display("FAIL midfill_after got addr=%0d ptr=%b cnt=%0d required addr=1 ptr=1 cnt=%0d",
                     wr_addr, wptr, wr_count, e.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap_around();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
